// File: rtl/fitbit_pkg.sv
// Shared types and default constants for the fitness tracker
// and the display mux that reads its outputs.
package fitbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIGH = 2'd2
  } ha_state_e;

  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_CLK_HZ         = 100000000;
  localparam int unsigned DEF_SI_LIMIT       = 9999;
  localparam int unsigned DEF_STEPS_PER_DIST = 2048;
  localparam int unsigned DEF_INIT_WINDOW    = 9;
  localparam int unsigned DEF_INIT_THRESH    = 32;
  localparam int unsigned DEF_HIGH_THRESH    = 64;
  localparam int unsigned DEF_HIGH_RUN       = 60;

endpackage

// File: rtl/fitbit_sec_timer.sv
// One-second timebase: free-running cycle counter that only
// advances while enabled and pulses tick at its terminal count.
module fitbit_sec_timer
  import fitbit_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic tick
);

  localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLK_HZ - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = EN & (cnt_q == LAST);
    cnt_d = cnt_q;
    if (EN) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fitbit_tracker.sv
// Step counter with distance, saturation flag, initial-window
// activity count and sustained high-activity time.
module fitbit_tracker
  import fitbit_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned SI_LIMIT       = DEF_SI_LIMIT,
  parameter int unsigned STEPS_PER_DIST = DEF_STEPS_PER_DIST,
  parameter int unsigned INIT_WINDOW    = DEF_INIT_WINDOW,
  parameter int unsigned INIT_THRESH    = DEF_INIT_THRESH,
  parameter int unsigned HIGH_THRESH    = DEF_HIGH_THRESH,
  parameter int unsigned HIGH_RUN       = DEF_HIGH_RUN
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             PULSE,
  output logic             SI,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] distance_covered,
  output logic [3:0]       initial_activity_count,
  output logic [CNT_W-1:0] high_activity_time
);

  localparam int unsigned SUB_W =
    (STEPS_PER_DIST > 1) ? $clog2(STEPS_PER_DIST) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS_PER_DIST - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_LEN  = CNT_W'(HIGH_RUN);
  localparam logic [3:0]       WIN      = 4'(INIT_WINDOW);

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic             tick;
  logic             step;
  logic             hi;
  logic [CNT_W-1:0] sps_eval;
  logic [CNT_W-1:0] run_inc;

  logic             pulse_q;
  logic             si_q, si_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [CNT_W-1:0] dist_q, dist_d;
  logic [CNT_W-1:0] sps_q, sps_d;
  logic [3:0]       sec_q, sec_d;
  logic [3:0]       iac_q, iac_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] hat_q, hat_d;
  ha_state_e        state_q, state_d;

  fitbit_sec_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_timer (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (START),
    .tick (tick)
  );

  always_comb begin
    step         = PULSE & ~pulse_q & START;
    step_count_d = step ? sat_add(step_count_q, ONE) : step_count_q;
    si_d         = si_q | (step_count_q > CNT_W'(SI_LIMIT));

    sub_d  = sub_q;
    dist_d = dist_q;
    if (step) begin
      if (sub_q == SUB_LAST) begin
        sub_d  = '0;
        dist_d = sat_add(dist_q, ONE);
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    // a step landing on the tick cycle closes out the ending second
    sps_eval = sat_add(sps_q, {{(CNT_W-1){1'b0}}, step});
    sps_d    = tick ? '0 : sps_eval;
    hi       = sps_eval > CNT_W'(HIGH_THRESH);

    sec_d = sec_q;
    iac_d = iac_q;
    if (tick && (sec_q < WIN)) begin
      sec_d = sec_q + 4'd1;
      if (sps_eval > CNT_W'(INIT_THRESH)) begin
        iac_d = iac_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pulse_q      <= 1'b0;
      si_q         <= 1'b0;
      step_count_q <= '0;
      sub_q        <= '0;
      dist_q       <= '0;
      sps_q        <= '0;
      sec_q        <= '0;
      iac_q        <= '0;
      run_q        <= '0;
      hat_q        <= '0;
    end else begin
      pulse_q      <= PULSE;
      si_q         <= si_d;
      step_count_q <= step_count_d;
      sub_q        <= sub_d;
      dist_q       <= dist_d;
      sps_q        <= sps_d;
      sec_q        <= sec_d;
      iac_q        <= iac_d;
      run_q        <= run_d;
      hat_q        <= hat_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign run_inc = run_q + ONE;

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: if (hi) state_d = ST_RUN;
        ST_RUN: begin
          if (!hi) begin
            state_d = ST_IDLE;
          end else if (run_inc == RUN_LEN) begin
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: if (!hi) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // a run only earns credit once it reaches full length
  always_comb begin
    run_d = run_q;
    hat_d = hat_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: run_d = hi ? ONE : '0;
        ST_RUN: begin
          if (!hi) begin
            run_d = '0;
          end else begin
            run_d = run_inc;
            if (run_inc == RUN_LEN) begin
              hat_d = sat_add(hat_q, RUN_LEN);
            end
          end
        end
        ST_HIGH: begin
          if (hi) begin
            hat_d = sat_add(hat_q, ONE);
          end else begin
            run_d = '0;
          end
        end
        default: run_d = '0;
      endcase
    end
  end

  assign SI                     = si_q;
  assign step_count             = step_count_q;
  assign distance_covered       = dist_q;
  assign initial_activity_count = iac_q;
  assign high_activity_time     = hat_q;

endmodule

// File: tb/tb_fitbit_tracker.sv
// Bench for fitbit_tracker: table vectors, directed sequences and
// random traffic against a per-second behavioural model.
module tb_fitbit_tracker;

  localparam int CLK_HZ = 200;
  localparam int SI_LIM = 9999;
  localparam int SPD    = 2048;
  localparam int IW     = 9;
  localparam int IT     = 32;
  localparam int HT     = 64;
  localparam int HR     = 60;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        PULSE = 1'b0;
  logic        SI;
  logic [31:0] step_count;
  logic [31:0] distance_covered;
  logic [3:0]  initial_activity_count;
  logic [31:0] high_activity_time;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  fitbit_tracker #(
    .CLK_HZ(CLK_HZ)
  ) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .START                 (START),
    .PULSE                 (PULSE),
    .SI                    (SI),
    .step_count            (step_count),
    .distance_covered      (distance_covered),
    .initial_activity_count(initial_activity_count),
    .high_activity_time    (high_activity_time)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_steps, m_cyc, m_cur, m_iac, m_hat;
  bit m_pq, m_si, m_st;
  int m_secs[$];

  // credit = length of every high run that reached HR seconds
  function automatic int hat_of(input int q[$]);
    int run = 0;
    int tot = 0;
    foreach (q[i]) begin
      if (q[i] > HT) begin
        run++;
      end else begin
        if (run >= HR) tot += run;
        run = 0;
      end
    end
    if (run >= HR) tot += run;
    return tot;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_steps = 0; m_cyc = 0; m_cur = 0; m_iac = 0; m_hat = 0;
      m_pq = 0; m_si = 0;
      m_secs.delete();
    end else begin
      m_st  = PULSE && !m_pq && START;
      m_pq  = PULSE;
      m_si  = m_si || (m_steps > SI_LIM);
      if (m_st) m_steps++;
      if (START) begin
        m_cyc++;
        if (m_st) m_cur++;
        if (m_cyc % CLK_HZ == 0) begin
          m_secs.push_back(m_cur);
          m_cur = 0;
          m_iac = 0;
          foreach (m_secs[i])
            if (i < IW && m_secs[i] > IT) m_iac++;
          m_hat = hat_of(m_secs);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET && chk_on) begin
      chk("m_steps", step_count, m_steps);
      chk("m_dist", distance_covered, m_steps / SPD);
      chk("m_si", SI, m_si);
      chk("m_iac", initial_activity_count, m_iac);
      chk("m_hat", high_activity_time, m_hat);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic start;
    logic pulse;
    int   exp_steps;
    int   exp_dist;
    logic exp_si;
  } vec_t;

  vec_t tbl[$];

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      START = tbl[i].start;
      PULSE = tbl[i].pulse;
      @(negedge CLK);
      chk($sformatf("tbl%0d_steps", i), step_count, tbl[i].exp_steps);
      chk($sformatf("tbl%0d_dist", i), distance_covered, tbl[i].exp_dist);
      chk($sformatf("tbl%0d_si", i), SI, tbl[i].exp_si);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 0; START = 0; PULSE = 0;
    repeat (2) @(negedge CLK);
    RESET = 1;
  endtask

  // n steps on odd cycles, optional extra step on the tick cycle
  task automatic ds(input int n, input bit ts, input int ncyc = CLK_HZ);
    for (int c = 0; c < ncyc; c++) begin
      START = 1;
      PULSE = ((c % 2 == 1) && (c < 2 * n)) || (ts && c == CLK_HZ - 1);
      @(negedge CLK);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 5; p++) begin
      for (int w = 0; w < 3; w++) tbl.push_back('{1, 1, p + 1, 0, 0});
      tbl.push_back('{1, 0, p + 1, 0, 0});
    end
    tbl.push_back('{0, 1, 5, 0, 0});
    tbl.push_back('{1, 1, 5, 0, 0});
    tbl.push_back('{1, 0, 5, 0, 0});
    tbl.push_back('{1, 1, 6, 0, 0});
    tbl.push_back('{1, 0, 6, 0, 0});

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_steps", step_count, 0);
    chk("rst_dist", distance_covered, 0);
    chk("rst_si", SI, 0);
    chk("rst_iac", initial_activity_count, 0);
    chk("rst_hat", high_activity_time, 0);
    @(negedge CLK);
    RESET = 1;
    chk_on = 1;

    apply(0, 20);

    for (int c = 0; c < 3 * CLK_HZ; c++) begin
      START = 0;
      PULSE = (c % 30) < 3;
      @(negedge CLK);
    end
    chk("stop_steps", step_count, 5);
    chk("stop_dist", distance_covered, 0);
    chk("stop_hat", high_activity_time, 0);

    apply(20, 25);

    for (int k = 6; k < 10003; k++) begin
      START = 1; PULSE = 1;
      @(negedge CLK);
      if (k + 1 == 2047) chk("dist_2047", distance_covered, 0);
      if (k + 1 == 2048) begin
        chk("steps_2048", step_count, 2048);
        chk("dist_2048", distance_covered, 1);
      end
      if (k + 1 == 10000) begin
        chk("steps_10000", step_count, 10000);
        chk("si_at_10000", SI, 0);
      end
      PULSE = 0;
      @(negedge CLK);
      if (k + 1 == 9999) chk("si_9999", SI, 0);
      if (k + 1 == 10000) chk("si_after_10000", SI, 1);
    end
    chk("si_sticky", SI, 1);
    chk("dist_10003", distance_covered, 4);

    do_reset();
    ds(32, 1);
    chk("iac_tick_step", initial_activity_count, 1);
    ds(33, 0); ds(33, 0); ds(32, 0);
    chk("iac_s4", initial_activity_count, 3);
    repeat (5) ds(40, 0);
    chk("iac_s9", initial_activity_count, 8);
    repeat (3) ds(40, 0);
    chk("iac_s12", initial_activity_count, 8);

    do_reset();
    repeat (59) ds(70, 0);
    chk("hat_59", high_activity_time, 0);
    ds(70, 0);
    chk("hat_60", high_activity_time, 60);
    repeat (5) ds(70, 0);
    chk("hat_65", high_activity_time, 65);
    ds(10, 0);
    chk("hat_low", high_activity_time, 65);
    repeat (59) ds(70, 0);
    ds(10, 0);
    chk("hat_short_run", high_activity_time, 65);

    repeat (3) ds(70, 0);
    ds(70, 0, 100);
    @(posedge CLK);
    #2;
    RESET = 0;
    #1;
    chk("arst_steps", step_count, 0);
    chk("arst_dist", distance_covered, 0);
    chk("arst_si", SI, 0);
    chk("arst_iac", initial_activity_count, 0);
    chk("arst_hat", high_activity_time, 0);
    START = 0; PULSE = 0;
    repeat (2) @(negedge CLK);
    RESET = 1;
    repeat (59) ds(70, 0);
    chk("post_rst_steps", step_count, 59 * 70);
    chk("post_rst_hat59", high_activity_time, 0);
    ds(70, 0);
    chk("post_rst_hat60", high_activity_time, 60);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      START = ($urandom_range(0, 9) != 0);
      PULSE = ($urandom_range(0, 2) == 0);
      @(negedge CLK);
    end
    for (int s = 0; s < 30; s++) begin
      ds($urandom_range(0, 90), $urandom_range(0, 1));
    end

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
